// File: rtl/mem_responder.sv
// Single-port word memory behind a valid/ready request/response handshake,
// with a programmable number of wait states between request and response.
module mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              rsp_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } state_e;

  localparam int unsigned DEPTH     = 2 ** ADDR_W;
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

  state_e              state_q, state_d;
  logic [3:0]          wait_cnt_q, wait_cnt_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                req_hs;
  logic                enter_rsp;
  logic                mem_we;

  assign req_hs = req_valid & req_ready_q;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    enter_rsp  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_hs) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d   = RESPOND;
            enter_rsp = 1'b1;
          end else begin
            state_d    = WAIT;
            wait_cnt_d = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        // The edge that sees a count of 1 is the WAIT_CYCLES-th edge in WAIT.
        if (wait_cnt_q <= 4'd1) begin
          state_d    = RESPOND;
          wait_cnt_d = '0;
          enter_rsp  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      RESPOND: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESPOND);
  end

  // we_d/addr_d/wdata_d carry the live request on the zero-wait path and the
  // latched copy otherwise, so one commit path serves both cases.
  always_comb begin
    mem_we      = enter_rsp & we_d;
    rsp_rdata_d = rsp_rdata_q;
    if (enter_rsp) begin
      rsp_rdata_d = we_d ? wdata_d : mem_q[addr_d];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  // Storage survives reset; reset only blocks a pending commit via the FSM.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[addr_d] <= wdata_d;
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed scoreboard bench for mem_responder: one instance with two wait
// states, one with none, sharing a clock.
module tb_mem_responder;

  localparam int AW = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset     [2];
  logic          req_valid [2];
  logic          req_ready [2];
  logic          req_we    [2];
  logic [AW-1:0] req_addr  [2];
  logic [DW-1:0] req_wdata [2];
  logic          rsp_valid [2];
  logic [DW-1:0] rsp_rdata [2];
  logic          rsp_ready [2];
  logic          busy      [2];

  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_ready(rsp_ready[0]),
    .busy(busy[0])
  );

  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_ready(rsp_ready[1]),
    .busy(busy[1])
  );

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] mdl   [2][256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input int d, input string tag);
    chk($sformatf("d%0d_%s_req_ready", d, tag), 32'(req_ready[d]), 32'd0);
    chk($sformatf("d%0d_%s_rsp_valid", d, tag), 32'(rsp_valid[d]), 32'd0);
    chk($sformatf("d%0d_%s_rsp_rdata", d, tag), 32'(rsp_rdata[d]), 32'd0);
    chk($sformatf("d%0d_%s_busy", d, tag), 32'(busy[d]), 32'd0);
  endtask

  // One complete transaction; hold = cycles of rsp_ready=0 backpressure.
  task automatic txn(input int d, input logic we, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wdata, input int hold, input int exp_lat);
    int            lat;
    logic [DW-1:0] exp;
    @(negedge clk);
    chk($sformatf("d%0d_req_ready_idle", d), 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    rsp_ready[d] = (hold == 0);
    if (we) mdl[d][addr] = wdata;
    exp_q.push_back(mdl[d][addr]);
    @(negedge clk);
    // Scramble the request inputs: they must no longer matter.
    req_valid[d] = 1'b0;
    req_we[d]    = ~we;
    req_addr[d]  = ~addr;
    req_wdata[d] = 8'hA5;
    chk($sformatf("d%0d_busy_after_hs", d), 32'(busy[d]), 32'd1);
    chk($sformatf("d%0d_req_ready_after_hs", d), 32'(req_ready[d]), 32'd0);
    lat = 1;
    while (rsp_valid[d] !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("d%0d_rsp_latency", d), 32'(lat), 32'(exp_lat));
    exp = exp_q.pop_front();
    chk($sformatf("d%0d_rsp_rdata", d), 32'(rsp_rdata[d]), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      req_valid[d] = i[0];
      @(negedge clk);
      chk($sformatf("d%0d_hold_rsp_valid", d), 32'(rsp_valid[d]), 32'd1);
      chk($sformatf("d%0d_hold_rsp_rdata", d), 32'(rsp_rdata[d]), 32'(exp));
      chk($sformatf("d%0d_hold_req_ready", d), 32'(req_ready[d]), 32'd0);
    end
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    chk($sformatf("d%0d_rsp_valid_done", d), 32'(rsp_valid[d]), 32'd0);
    chk($sformatf("d%0d_req_ready_done", d), 32'(req_ready[d]), 32'd1);
    chk($sformatf("d%0d_busy_done", d), 32'(busy[d]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    // Reset held with a request pending: no handshake may occur.
    for (int d = 0; d < 2; d++) begin
      reset[d]     = 1'b0;
      req_valid[d] = 1'b1;
      req_we[d]    = 1'b1;
      req_addr[d]  = 8'h55;
      req_wdata[d] = 8'h99;
      rsp_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) chk_reset_outputs(d, "in_reset");
    #2;
    for (int d = 0; d < 2; d++) reset[d] = 1'b1;
    #1;
    for (int d = 0; d < 2; d++)
      chk($sformatf("d%0d_req_ready_before_edge", d), 32'(req_ready[d]), 32'd0);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_req_ready_after_release", d), 32'(req_ready[d]), 32'd1);
      chk($sformatf("d%0d_busy_after_release", d), 32'(busy[d]), 32'd0);
      req_valid[d] = 1'b0;
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      chk($sformatf("d%0d_no_hs_in_reset", d), 32'(busy[d]), 32'd0);

    // Two wait states: latency 3 negedges after the handshake edge.
    txn(0, 1'b1, 8'h01, 8'h11, 0, 3);
    txn(0, 1'b1, 8'h10, 8'h5A, 0, 3);
    txn(0, 1'b0, 8'h10, 8'h00, 0, 3);
    txn(0, 1'b0, 8'h10, 8'h00, 5, 3);

    // Reset during WAIT aborts an uncommitted write.
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 8'h01;
    req_wdata[0] = 8'h77;
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    chk("d0_busy_in_wait", 32'(busy[0]), 32'd1);
    #2 reset[0] = 1'b0;
    #1 chk_reset_outputs(0, "abort_wait");
    @(negedge clk);
    reset[0] = 1'b1;
    @(negedge clk);
    chk("d0_req_ready_after_abort", 32'(req_ready[0]), 32'd1);
    txn(0, 1'b0, 8'h01, 8'h00, 0, 3);

    // Reset during RESPOND: rsp_valid drops at once, committed write stays.
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 8'h20;
    req_wdata[0] = 8'h42;
    rsp_ready[0] = 1'b0;
    mdl[0][8'h20] = 8'h42;
    @(negedge clk);
    req_valid[0] = 1'b0;
    lat = 1;
    while (rsp_valid[0] !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("d0_rsp_valid_before_reset", 32'(rsp_valid[0]), 32'd1);
    #2 reset[0] = 1'b0;
    #1 chk_reset_outputs(0, "abort_respond");
    @(negedge clk);
    reset[0] = 1'b1;
    @(negedge clk);
    chk("d0_req_ready_after_rsp_abort", 32'(req_ready[0]), 32'd1);
    txn(0, 1'b0, 8'h20, 8'h00, 0, 3);

    // Zero wait states: response in the cycle after the handshake; top address.
    txn(1, 1'b1, 8'h00, 8'h44, 0, 1);
    txn(1, 1'b1, 8'hFF, 8'h33, 0, 1);
    txn(1, 1'b0, 8'hFF, 8'h00, 0, 1);
    txn(1, 1'b0, 8'h00, 8'h00, 0, 1);
    txn(1, 1'b0, 8'hFF, 8'h00, 3, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
